// File: rtl/qed_pkg.sv
`default_nettype none
// ============================================================================
// Module      : qed_pkg
// Description : Opcodes, instruction classes and FSM states for the QED
//               duplicate-instruction stream.
// Revision    : 1.0 - initial release
// ============================================================================
package qed_pkg;

    localparam logic [6:0] c_OP_R     = 7'b0110011;
    localparam logic [6:0] c_OP_I     = 7'b0010011;
    localparam logic [6:0] c_OP_LUI   = 7'b0110111;
    localparam logic [6:0] c_OP_AUIPC = 7'b0010111;
    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_LUI,
        CLS_AUIPC,
        CLS_LOAD,
        CLS_STORE,
        CLS_BARRIER
    } instr_cls_e;

    typedef enum logic [0:0] {
        ST_ORIG,
        ST_DRAIN
    } state_e;

endpackage
`default_nettype wire

// File: rtl/qed_dup_transform.sv
`default_nettype none
// ============================================================================
// Module      : qed_dup_transform
// Description : Combinational class decode, EDDI-V duplicate transform and
//               register-range check for one instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module qed_dup_transform
    import qed_pkg::*;
#(
    parameter int REG_AW       = 5,
    parameter int MEM_PART_BIT = 6
) (
    input  logic [31:0] i_instr,
    output logic [31:0] o_dup_instr,
    output logic        o_barrier,
    output logic        o_reg_err
);

    localparam logic [4:0]  c_REG_HI   = 5'(1 << (REG_AW - 1));
    localparam logic [11:0] c_PART     = 12'(1 << MEM_PART_BIT);
    localparam logic [11:0] c_LOW_MASK = 12'((1 << MEM_PART_BIT) - 1);

    instr_cls_e  w_cls;
    logic        w_has_rd;
    logic        w_has_rs1;
    logic        w_has_rs2;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [11:0] w_ld_imm;
    logic [11:0] w_st_imm;

    // x0 must stay x0 so the duplicate keeps its hard-wired-zero semantics
    function automatic logic [4:0] f_dup_reg(input logic [4:0] r);
        return (r == 5'd0) ? r : (r | c_REG_HI);
    endfunction

    always_comb begin
        w_cls = CLS_BARRIER;
        case (i_instr[6:0])
            c_OP_R:     w_cls = CLS_R;
            c_OP_I:     w_cls = CLS_I;
            c_OP_LUI:   w_cls = CLS_LUI;
            c_OP_AUIPC: w_cls = CLS_AUIPC;
            c_OP_LOAD:  w_cls = CLS_LOAD;
            c_OP_STORE: w_cls = CLS_STORE;
            default:    w_cls = CLS_BARRIER;
        endcase
    end

    assign w_rd      = i_instr[11:7];
    assign w_rs1     = i_instr[19:15];
    assign w_rs2     = i_instr[24:20];
    assign w_has_rd  = (w_cls == CLS_R) || (w_cls == CLS_I) || (w_cls == CLS_LUI)
                    || (w_cls == CLS_AUIPC) || (w_cls == CLS_LOAD);
    assign w_has_rs1 = (w_cls == CLS_R) || (w_cls == CLS_I)
                    || (w_cls == CLS_LOAD) || (w_cls == CLS_STORE);
    assign w_has_rs2 = (w_cls == CLS_R) || (w_cls == CLS_STORE);

    assign w_ld_imm  = c_PART | (i_instr[31:20] & c_LOW_MASK);
    assign w_st_imm  = c_PART | ({i_instr[31:25], i_instr[11:7]} & c_LOW_MASK);

    always_comb begin
        o_dup_instr = i_instr;
        if (w_has_rd)  o_dup_instr[11:7]  = f_dup_reg(w_rd);
        if (w_has_rs1) o_dup_instr[19:15] = f_dup_reg(w_rs1);
        if (w_has_rs2) o_dup_instr[24:20] = f_dup_reg(w_rs2);
        if (w_cls == CLS_LOAD) o_dup_instr[31:20] = w_ld_imm;
        if (w_cls == CLS_STORE) begin
            o_dup_instr[31:25] = w_st_imm[11:5];
            o_dup_instr[11:7]  = w_st_imm[4:0];
        end
    end

    assign o_barrier = (w_cls == CLS_BARRIER);
    assign o_reg_err = (w_has_rd  && w_rd[REG_AW-1])
                    || (w_has_rs1 && w_rs1[REG_AW-1])
                    || (w_has_rs2 && w_rs2[REG_AW-1]);

endmodule
`default_nettype wire

// File: rtl/qed_dup_stream.sv
`default_nettype none
// ============================================================================
// Module      : qed_dup_stream
// Description : EDDI-V duplicate-instruction generator: passes originals,
//               queues duplicates and drains them as sequenced blocks.
// Revision    : 1.0 - initial release
// ============================================================================
module qed_dup_stream
    import qed_pkg::*;
#(
    parameter int REG_AW       = 5,
    parameter int MEM_PART_BIT = 6,
    parameter int DEPTH        = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   qed_ena,
    input  logic                   drain_req,
    input  logic [31:0]            in_instr,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [31:0]            out_instr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_is_dup,
    output logic [$clog2(DEPTH):0] fifo_count,
    output logic                   busy,
    output logic                   err_reg_range
);

    localparam int                 c_PTR_W   = $clog2(DEPTH);
    localparam int                 c_CNT_W   = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    state_e             r_state_q, w_state_d;
    logic               r_mode_q, w_mode_d;
    logic               r_err_q, w_err_d;
    logic [c_PTR_W-1:0] r_head_q, w_head_d;
    logic [c_PTR_W-1:0] r_tail_q, w_tail_d;
    logic [c_CNT_W-1:0] r_count_q, w_count_d;
    logic [31:0]        r_out_instr_q, w_out_instr_d;
    logic               r_out_valid_q, w_out_valid_d;
    logic               r_out_dup_q, w_out_dup_d;
    logic [31:0]        r_fifo_mem [DEPTH];

    logic        w_dup_instr;
    logic [31:0] w_dup;
    logic        w_barrier;
    logic        w_reg_err;
    logic        w_slot_free;
    logic        w_empty;
    logic        w_mode;
    logic        w_in_ready;
    logic        w_accept;
    logic        w_push;
    logic        w_pop;

    qed_dup_transform #(
        .REG_AW       (REG_AW),
        .MEM_PART_BIT (MEM_PART_BIT)
    ) u_transform (
        .i_instr     (in_instr),
        .o_dup_instr (w_dup),
        .o_barrier   (w_barrier),
        .o_reg_err   (w_reg_err)
    );

    assign w_dup_instr = !w_barrier;
    assign w_slot_free = !r_out_valid_q || out_ready;
    assign w_empty     = (r_count_q == '0);
    // Mode follows qed_ena only between blocks so a block never mixes modes
    assign w_mode      = (r_state_q == ST_ORIG && w_empty) ? qed_ena : r_mode_q;

    always_comb begin
        w_in_ready = 1'b0;
        if (r_state_q == ST_ORIG) begin
            if (!w_mode) w_in_ready = w_slot_free;
            else         w_in_ready = w_slot_free && (r_count_q != c_FULL)
                                   && !(w_barrier && !w_empty);
        end
    end

    assign w_accept = in_valid && w_in_ready;
    assign w_push   = w_accept && w_mode && w_dup_instr;
    assign w_pop    = (r_state_q == ST_DRAIN) && w_slot_free && !w_empty;

    always_comb begin
        w_head_d      = r_head_q;
        w_tail_d      = r_tail_q;
        w_count_d     = r_count_q;
        w_state_d     = r_state_q;
        w_mode_d      = w_mode;
        w_err_d       = r_err_q || (w_accept && w_mode && w_reg_err);
        w_out_instr_d = r_out_instr_q;
        w_out_valid_d = r_out_valid_q;
        w_out_dup_d   = r_out_dup_q;

        if (w_push) begin
            w_tail_d  = r_tail_q + c_PTR_ONE;
            w_count_d = r_count_q + c_CNT_ONE;
        end else if (w_pop) begin
            w_head_d  = r_head_q + c_PTR_ONE;
            w_count_d = r_count_q - c_CNT_ONE;
        end

        if (w_accept) begin
            w_out_valid_d = 1'b1;
            w_out_instr_d = in_instr;
            w_out_dup_d   = 1'b0;
        end else if (w_pop) begin
            w_out_valid_d = 1'b1;
            w_out_instr_d = r_fifo_mem[r_head_q];
            w_out_dup_d   = 1'b1;
        end else if (w_slot_free) begin
            w_out_valid_d = 1'b0;
        end

        case (r_state_q)
            ST_ORIG: begin
                if (w_mode && (w_count_d != '0) && ((w_count_d == c_FULL) || drain_req
                                                  || (in_valid && w_barrier)))
                    w_state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_pop && (w_count_d == '0)) w_state_d = ST_ORIG;
            end
            default: w_state_d = ST_ORIG;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= ST_ORIG;
            r_mode_q      <= 1'b0;
            r_err_q       <= 1'b0;
            r_head_q      <= '0;
            r_tail_q      <= '0;
            r_count_q     <= '0;
            r_out_instr_q <= '0;
            r_out_valid_q <= 1'b0;
            r_out_dup_q   <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_mode_q      <= w_mode_d;
            r_err_q       <= w_err_d;
            r_head_q      <= w_head_d;
            r_tail_q      <= w_tail_d;
            r_count_q     <= w_count_d;
            r_out_instr_q <= w_out_instr_d;
            r_out_valid_q <= w_out_valid_d;
            r_out_dup_q   <= w_out_dup_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo_mem[r_tail_q] <= w_dup;
    end

    assign in_ready      = w_in_ready;
    assign out_instr     = r_out_instr_q;
    assign out_valid     = r_out_valid_q;
    assign out_is_dup    = r_out_dup_q;
    assign fifo_count    = r_count_q;
    assign busy          = (r_state_q == ST_DRAIN) || !w_empty;
    assign err_reg_range = r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_qed_dup_stream.sv
`default_nettype none
// ============================================================================
// Module      : tb_qed_dup_stream
// Description : Randomized and directed bench for qed_dup_stream against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qed_dup_stream;

    localparam int DEPTH        = 8;
    localparam int REG_AW       = 5;
    localparam int MEM_PART_BIT = 6;
    localparam int CW           = $clog2(DEPTH) + 1;

    localparam logic [31:0] c_ADD   = 32'h002081B3;
    localparam logic [31:0] c_ADD17 = 32'h00208833;
    localparam logic [31:0] c_LW    = 32'h0080A283;
    localparam logic [31:0] c_NOP   = 32'h00000013;
    localparam logic [31:0] c_SW    = 32'h0020A623;
    localparam logic [31:0] c_BEQ   = 32'h00208463;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          qed_ena = 1'b0;
    logic          drain_req = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic [31:0]   in_instr = '0;
    logic          in_ready;
    logic          out_valid;
    logic          out_is_dup;
    logic          busy;
    logic          err_reg_range;
    logic [31:0]   out_instr;
    logic [CW-1:0] fifo_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    qed_dup_stream #(
        .REG_AW       (REG_AW),
        .MEM_PART_BIT (MEM_PART_BIT),
        .DEPTH        (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .qed_ena       (qed_ena),
        .drain_req     (drain_req),
        .in_instr      (in_instr),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_instr     (out_instr),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_is_dup    (out_is_dup),
        .fifo_count    (fifo_count),
        .busy          (busy),
        .err_reg_range (err_reg_range)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] dq[$];
    bit          m_drain, m_mode, m_err, m_valid, m_dup, m_live;
    logic [31:0] m_instr;

    function automatic bit is_dupable(input logic [31:0] i);
        return i[6:0] inside {7'h33, 7'h13, 7'h37, 7'h17, 7'h03, 7'h23};
    endfunction

    function automatic bit uses_rd(input logic [6:0] op);
        return op inside {7'h33, 7'h13, 7'h37, 7'h17, 7'h03};
    endfunction

    function automatic bit uses_rs1(input logic [6:0] op);
        return op inside {7'h33, 7'h13, 7'h03, 7'h23};
    endfunction

    function automatic bit uses_rs2(input logic [6:0] op);
        return op inside {7'h33, 7'h23};
    endfunction

    function automatic logic [4:0] hi_reg(input logic [4:0] r);
        int half = 2 ** (REG_AW - 1);
        if (r == 0) return r;
        return (int'(r) % (2 * half) >= half) ? r : 5'(int'(r) + half);
    endfunction

    function automatic bit reg_hit(input logic [31:0] i);
        int half = 2 ** (REG_AW - 1);
        return (uses_rd(i[6:0])  && (int'(i[11:7])  % (2 * half) >= half))
            || (uses_rs1(i[6:0]) && (int'(i[19:15]) % (2 * half) >= half))
            || (uses_rs2(i[6:0]) && (int'(i[24:20]) % (2 * half) >= half));
    endfunction

    function automatic logic [31:0] ref_dup(input logic [31:0] i);
        logic [6:0]  op  = i[6:0];
        logic [4:0]  rd  = uses_rd(op)  ? hi_reg(i[11:7])  : i[11:7];
        logic [4:0]  rs1 = uses_rs1(op) ? hi_reg(i[19:15]) : i[19:15];
        logic [4:0]  rs2 = uses_rs2(op) ? hi_reg(i[24:20]) : i[24:20];
        int          part = 2 ** MEM_PART_BIT;
        logic [11:0] imm;
        case (op)
            7'h03: begin
                imm = 12'(part + int'(i[31:20]) % part);
                return {imm, rs1, i[14:12], rd, op};
            end
            7'h23: begin
                imm = 12'(part + int'({i[31:25], i[11:7]}) % part);
                return {imm[11:5], rs2, rs1, i[14:12], imm[4:0], op};
            end
            7'h33:          return {i[31:25], rs2, rs1, i[14:12], rd, op};
            7'h13:          return {i[31:20], rs1, i[14:12], rd, op};
            7'h37, 7'h17:   return {i[31:12], rd, op};
            default:        return i;
        endcase
    endfunction

    function automatic bit m_eff_mode();
        return (!m_drain && dq.size() == 0) ? qed_ena : m_mode;
    endfunction

    function automatic bit m_ready();
        bit slot = !m_valid || out_ready;
        if (m_drain) return 1'b0;
        if (!m_eff_mode()) return slot;
        return slot && dq.size() < DEPTH && (is_dupable(in_instr) || dq.size() == 0);
    endfunction

    task automatic m_step();
        bit slot, mode, rdy, was_drain;
        if (rst) begin
            dq.delete();
            m_drain = 0; m_mode = 0; m_err = 0;
            m_valid = 0; m_dup = 0; m_instr = '0; m_live = 1;
            return;
        end
        slot      = !m_valid || out_ready;
        mode      = m_eff_mode();
        rdy       = m_ready();
        was_drain = m_drain;
        if (in_valid && rdy) begin
            m_valid = 1; m_instr = in_instr; m_dup = 0;
            if (mode && is_dupable(in_instr)) dq.push_back(ref_dup(in_instr));
            if (mode && reg_hit(in_instr)) m_err = 1;
        end else if (was_drain && slot && dq.size() > 0) begin
            m_valid = 1; m_instr = dq.pop_front(); m_dup = 1;
            if (dq.size() == 0) m_drain = 0;
        end else if (slot) begin
            m_valid = 0;
        end
        if (!was_drain && mode && dq.size() > 0 &&
            (dq.size() == DEPTH || drain_req || (in_valid && !is_dupable(in_instr))))
            m_drain = 1;
        m_mode = mode;
    endtask

    // Inputs only change at the falling edge or 1 ns after it
    always @(negedge clk) begin
        #2;
        if (m_live) begin
            chk("out_valid",  32'(out_valid),     32'(m_valid));
            chk("out_is_dup", 32'(out_is_dup),    32'(m_dup));
            chk("out_instr",  out_instr,          m_instr);
            chk("fifo_count", 32'(fifo_count),    32'(dq.size()));
            chk("busy",       32'(busy),          32'(m_drain || dq.size() != 0));
            chk("err",        32'(err_reg_range), 32'(m_err));
            chk("in_ready",   32'(in_ready),      32'(m_ready()));
        end
        m_step();
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [31:0] ins);
        bit ok = 0;
        in_instr = ins;
        in_valid = 1'b1;
        for (int k = 0; k < 100 && !ok; k++) begin
            #1;
            ok = in_ready;
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_drain();
        drain_req = 1'b1;
        @(negedge clk);
        drain_req = 1'b0;
    endtask

    task automatic wait_dup(input string nm, input logic [31:0] exp);
        bit seen = 0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            #1;
            seen = out_valid && out_is_dup;
        end
        chk(nm, seen ? out_instr : 32'hDEADBEEF, exp);
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [6:0]  ops [10] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h03,
                                  7'h23, 7'h63, 7'h6F, 7'h73, 7'h0F};
        logic [31:0] r   = $urandom;
        int          idx = $urandom_range(0, 10);
        if (idx < 10) r[6:0] = ops[idx];
        if ($urandom_range(0, 1) == 1) begin
            r[11] = 1'b0; r[19] = 1'b0; r[24] = 1'b0;
        end
        return r;
    endfunction

    // ---------------- directed + random sequence ----------------
    logic [31:0] snap_instr;
    logic [CW-1:0] snap_cnt;

    initial begin
        chk("ref_add",   ref_dup(c_ADD), 32'h012889B3);
        chk("ref_lw",    ref_dup(c_LW),  32'h0488AA83);
        chk("ref_nop",   ref_dup(c_NOP), 32'h00000013);
        chk("ref_sw",    ref_dup(c_SW),  32'h0528A623);
        chk("ref_beq",   ref_dup(c_BEQ), c_BEQ);

        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_instr", out_instr, 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_err",   32'(err_reg_range), 32'd0);
        rst = 1'b0;
        qed_ena = 1'b1;
        @(negedge clk);

        send(c_ADD);
        chk("add_orig", out_instr, c_ADD);
        chk("add_orig_dup", 32'(out_is_dup), 32'd0);
        chk("add_count", 32'(fifo_count), 32'd1);
        pulse_drain();
        wait_dup("add_dup", 32'h012889B3);

        @(negedge clk);
        send(c_LW);
        pulse_drain();
        wait_dup("lw_dup", 32'h0488AA83);
        @(negedge clk);
        send(c_NOP);
        pulse_drain();
        wait_dup("nop_dup", 32'h00000013);

        @(negedge clk);
        for (int n = 0; n < DEPTH; n++) send(c_ADD);
        #1;
        chk("full_stall", 32'(in_ready), 32'd0);
        @(negedge clk);
        send(c_ADD);
        chk("after_full_count", 32'(fifo_count), 32'd1);
        chk("after_full_orig", out_instr, c_ADD);
        pulse_drain();
        wait_dup("after_full_dup", 32'h012889B3);

        @(negedge clk);
        send(c_ADD);
        send(32'h00208233);
        send(c_BEQ);
        chk("beq_out", out_instr, c_BEQ);
        chk("beq_dup", 32'(out_is_dup), 32'd0);
        chk("beq_count", 32'(fifo_count), 32'd0);

        send(c_ADD);
        send(32'h00208233);
        send(32'h002082B3);
        send(32'h00208333);
        pulse_drain();
        wait_dup("stall_first", 32'h012889B3);
        out_ready = 1'b0;
        snap_instr = out_instr;
        snap_cnt = fifo_count;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            #1;
            chk("stall_instr", out_instr, snap_instr);
            chk("stall_count", 32'(fifo_count), 32'(snap_cnt));
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_instr", out_instr, 32'd0);
        chk("mid_rst_count", 32'(fifo_count), 32'd0);
        chk("mid_rst_busy",  32'(busy), 32'd0);
        rst = 1'b0;
        out_ready = 1'b1;

        @(negedge clk);
        qed_ena = 1'b0;
        send(c_ADD17);
        chk("pt_out", out_instr, c_ADD17);
        chk("pt_count", 32'(fifo_count), 32'd0);
        chk("pt_err", 32'(err_reg_range), 32'd0);
        qed_ena = 1'b1;
        send(c_ADD17);
        chk("qed_err", 32'(err_reg_range), 32'd1);
        pulse_drain();
        repeat (6) @(negedge clk);
        chk("err_sticky", 32'(err_reg_range), 32'd1);

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst       = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 59) == 0) qed_ena = ~qed_ena;
            in_valid  = ($urandom_range(0, 9) < 7);
            in_instr  = rnd_instr();
            out_ready = ($urandom_range(0, 3) != 0);
            drain_req = ($urandom_range(0, 9) == 0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        drain_req = 1'b0;
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
